logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Parametrised, pipelined logic unit: the successor to the 2-bit-select, single-bit combinational gate selector. It applies one of eight bitwise operations to WIDTH-bit operands and passes each result through a two-stage pipeline with valid/ready handshakes on both sides. It adds an accumulator mode, where operand B comes from the previous result, plus registered zero/parity flags and a saturating transfer counter. It sits between a producer and a consumer stream that both use valid/ready flow control.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- CNT_W, 16, width of the transfer counter (≥1)

- clk  in  1  sole clock; all registers on the rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- in_valid  in  1  producer has a transaction on sel/a/b/acc_en/acc_clr
- in_ready  out  1  block can accept; a transaction is accepted on an edge where in_valid && in_ready
- sel  in  3  operation select
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored when acc_en)
- acc_en  in  1  use the accumulator as operand B for this transaction
- acc_clr  in  1  synchronously clear the accumulator
- out_valid  out  1  y/zero/parity hold a result
- out_ready  in  1  consumer accepts; a result is transferred on an edge where out_valid && out_ready
- y  out  WIDTH  result
- zero  out  1  y == 0
- parity  out  1  XOR-reduction of y (odd parity = 1)
- op_count  out  CNT_W  saturating count of output transfers

## Operation
- sel encoding: 000 NOT a; 001 a AND b; 010 a OR b; 011 a XOR b; 100 NAND; 101 NOR; 110 XNOR; 111 PASS a. Codes 000–011 keep the legacy encoding.
- Effective operand B (b_eff):
  - 0 if acc_clr is high in the accepting cycle;
  - otherwise acc if acc_en is high;
  - otherwise b.
- Stage 1 (on accept): compute r = op(a, b_eff) combinationally and register it into s1 with s1_valid = 1. If acc_en is high, acc <= r in the same edge.
- acc_clr outside an accept with acc_en: acc <= 0. acc_clr with an accept that has acc_en: acc <= r (r already used 0 as its operand).
- Stage 2: on advance, s2 <= s1; zero and parity are computed from the s1 result and registered alongside y. Flags always match the y presented.
- Advance rules:
  - s2 loads when s1_valid && (!s2_valid || out_ready).
  - s1 loads on accept. It clears when it advances and no new accept occurs.
- in_ready = !rst && (!s1_valid || !s2_valid || out_ready). This is combinational; no combinational path from in_valid to in_ready.
- Capacity is 2 entries. Results leave strictly in acceptance order, with no loss or duplication.
- op_count increments on each output transfer and saturates at 2^CNT_W−1. Only rst clears it.
- No operand-width arithmetic; all operations are bitwise across the full WIDTH.

## Timing
- Reset values (asynchronous, immediate): out_valid=0, y=0, zero=0, parity=0, op_count=0, acc=0, s1_valid=0, in_ready=0.
- After reset deasserts, in_ready=1 in the same cycle.
- Reset mid-operation discards all in-flight entries and the accumulator. No stale result is ever presented.
- Latency: a transaction accepted at edge k gives out_valid=1 after edge k+1 when the pipeline is empty or flowing, i.e. two cycles from input presentation.
- Throughput is 1 per cycle with out_ready held high.
- Back-to-back acc_en transactions chain with no bubble: acc updates at accept.
- While out_valid && !out_ready, y, zero and parity hold stable.
- Backpressure: with out_ready low, 2 entries are accepted, then in_ready goes low. The first edge with out_ready high frees one slot, and in_ready rises in that same cycle.
- A simultaneous output transfer and accept when full is allowed; occupancy is unchanged.

## Test plan
- Reset: assert rst mid-cycle → all outputs 0 immediately and in_ready=0 while rst is high. Release → in_ready=1, out_valid=0.
- Op sweep (WIDTH=8, a=A5, b=3C), sel 0–7 back-to-back with out_ready=1 → y = 5A, 24, BD, 99, DB, 42, 66, A5. Each arrives 2 cycles after its input; out_valid stays continuous; op_count ends at 8.
- Backpressure: out_ready=0, offer 3 items (sel=001, a=FF, b=01/02/04) → exactly 2 accepted, in_ready=0, y=01 held. Raise out_ready → y = 01, 02, 04 in order with no duplicates.
- Accumulator: acc_clr=1 with acc_en=1, sel=011, a=0F → y=0F. Then acc_en with a=F0 → y=FF, parity=0. Then a=FF → y=00, zero=1.
- Flags and saturation (CNT_W=2): PASS a=07 → parity=1, zero=0. PASS a=00 → zero=1, parity=0. After 5 output transfers → op_count=3.
- Reset in flight: 2 entries held with out_ready=0, pulse rst → out_valid=0 and acc=0. The next accepted acc_en XOR a=3C yields y=3C.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides,
// accumulator operand mode, registered zero/parity flags and a saturating transfer count.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
);

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] s1_reg;
    logic             s1_valid_reg;
    logic             s2_valid_reg;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] r;
    logic             accept;
    logic             advance;
    logic             xfer;

    assign out_valid = s2_valid_reg;
    // Ready only depends on occupancy and out_ready, never on in_valid.
    assign in_ready  = !rst && (!s1_valid_reg || !s2_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign xfer      = s2_valid_reg && out_ready;
    assign advance   = s1_valid_reg && (!s2_valid_reg || out_ready);

    always_comb begin
        b_eff = b;
        if (acc_clr)
            b_eff = '0;
        else if (acc_en)
            b_eff = acc_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_comb begin
                r[gi] = 1'b0;
                case (sel)
                    3'b000: r[gi] = ~a[gi];
                    3'b001: r[gi] = a[gi] & b_eff[gi];
                    3'b010: r[gi] = a[gi] | b_eff[gi];
                    3'b011: r[gi] = a[gi] ^ b_eff[gi];
                    3'b100: r[gi] = ~(a[gi] & b_eff[gi]);
                    3'b101: r[gi] = ~(a[gi] | b_eff[gi]);
                    3'b110: r[gi] = ~(a[gi] ^ b_eff[gi]);
                    default: r[gi] = a[gi];
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg       <= '0;
            s1_valid_reg <= 1'b0;
            acc_reg      <= '0;
        end else begin
            if (accept)
                s1_reg <= r;
            if (accept)
                s1_valid_reg <= 1'b1;
            else if (advance)
                s1_valid_reg <= 1'b0;
            // An accepted acc_en result wins over a clear; its operand was already zeroed.
            if (accept && acc_en)
                acc_reg <= r;
            else if (acc_clr)
                acc_reg <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            y            <= '0;
            zero         <= 1'b0;
            parity       <= 1'b0;
        end else if (advance) begin
            s2_valid_reg <= 1'b1;
            y            <= s1_reg;
            zero         <= (s1_reg == '0);
            parity       <= ^s1_reg;
        end else if (xfer) begin
            s2_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            op_count <= '0;
        else if (xfer && (op_count != {CNT_W{1'b1}}))
            op_count <= op_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed, table-driven bench for logic_unit_pipe: output stream checked against a
// scoreboard of hand-computed results, plus sequences for reset, backpressure and saturation.
module tb_logic_unit_pipe;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       acc_en;
        logic       acc_clr;
        logic [7:0] ey;
        logic       ez;
        logic       ep;
        int         cyc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] sel = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       acc_en = 1'b0;
    logic       acc_clr = 1'b0;
    logic       in_ready, out_valid, zero, parity;
    logic [7:0] y;
    logic [15:0] op_count;
    logic       s_in_ready, s_out_valid, s_zero, s_parity;
    logic [7:0] s_y;
    logic [1:0] s_op_count;

    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    int   n_out = 0;
    bit   check_lat = 0;
    vec_t cur;
    vec_t tbl[21];
    vec_t q[$];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .a(a), .b(b), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero),
        .parity(parity), .op_count(op_count)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .sel(sel), .a(a), .b(b), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(s_out_valid), .out_ready(out_ready), .y(s_y), .zero(s_zero),
        .parity(s_parity), .op_count(s_op_count)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] s, input logic [7:0] va, input logic [7:0] vb,
                                input logic en, input logic clr, input logic [7:0] ey);
        vec_t v;
        v.sel = s; v.a = va; v.b = vb; v.acc_en = en; v.acc_clr = clr;
        v.ey = ey; v.ez = (ey == 8'h00); v.ep = ^ey; v.cyc = 0;
        return v;
    endfunction

    // Scoreboard: outputs are popped before this edge's accept is pushed.
    always @(negedge clk) begin
        vec_t e;
        cycle++;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = q.pop_front();
                check("y_zero_parity", {y, zero, parity}, {e.ey, e.ez, e.ep});
                if (check_lat) check("latency", cycle - e.cyc, 2);
                n_out++;
                $display("[TB] out y=%02h zero=%0b parity=%0b exp=%02h", y, zero, parity, e.ey);
            end
        end
        if (in_valid && in_ready) begin
            e = cur;
            e.cyc = cycle;
            q.push_back(e);
        end
    end

    task automatic present(input vec_t v);
        cur = v;
        in_valid = 1'b1; sel = v.sel; a = v.a; b = v.b; acc_en = v.acc_en; acc_clr = v.acc_clr;
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        bit got = 0;
        present(v);
        while (!got && n < 20) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) check("accept_timeout", 0, 1);
        in_valid = 1'b0; acc_clr = 1'b0; acc_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic pulse_rst();
        #3;
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {y, zero, parity, op_count}, 0);
        check("rst_in_ready", in_ready, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);
    endtask

    initial begin
        int base;
        tbl[0]  = mk(3'd0, 8'hA5, 8'h3C, 0, 0, 8'h5A);
        tbl[1]  = mk(3'd1, 8'hA5, 8'h3C, 0, 0, 8'h24);
        tbl[2]  = mk(3'd2, 8'hA5, 8'h3C, 0, 0, 8'hBD);
        tbl[3]  = mk(3'd3, 8'hA5, 8'h3C, 0, 0, 8'h99);
        tbl[4]  = mk(3'd4, 8'hA5, 8'h3C, 0, 0, 8'hDB);
        tbl[5]  = mk(3'd5, 8'hA5, 8'h3C, 0, 0, 8'h42);
        tbl[6]  = mk(3'd6, 8'hA5, 8'h3C, 0, 0, 8'h66);
        tbl[7]  = mk(3'd7, 8'hA5, 8'h3C, 0, 0, 8'hA5);
        tbl[8]  = mk(3'd1, 8'hFF, 8'h01, 0, 0, 8'h01);
        tbl[9]  = mk(3'd1, 8'hFF, 8'h02, 0, 0, 8'h02);
        tbl[10] = mk(3'd1, 8'hFF, 8'h04, 0, 0, 8'h04);
        tbl[11] = mk(3'd3, 8'h0F, 8'h77, 1, 1, 8'h0F);
        tbl[12] = mk(3'd3, 8'hF0, 8'h77, 1, 0, 8'hFF);
        tbl[13] = mk(3'd3, 8'hFF, 8'h77, 1, 0, 8'h00);
        tbl[14] = mk(3'd7, 8'h07, 8'hFF, 0, 0, 8'h07);
        tbl[15] = mk(3'd7, 8'h00, 8'hFF, 0, 0, 8'h00);
        tbl[16] = mk(3'd3, 8'h55, 8'h00, 1, 0, 8'h55);
        tbl[17] = mk(3'd3, 8'h0F, 8'h00, 1, 0, 8'h5A);
        tbl[18] = mk(3'd3, 8'h3C, 8'hAA, 1, 0, 8'h3C);
        tbl[19] = mk(3'd2, 8'h81, 8'h02, 0, 0, 8'h83);
        tbl[20] = mk(3'd0, 8'hF0, 8'h00, 0, 0, 8'h0F);

        // Reset state while rst is held from time zero.
        #1;
        check("init_in_ready", in_ready, 0);
        check("init_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("init_rel_in_ready", in_ready, 1);

        // Mid-cycle reset with a result pending at the output.
        out_ready = 1'b0;
        send(tbl[8]);
        @(posedge clk); #1;
        check("pre_rst_out_valid", out_valid, 1);
        pulse_rst();

        // Op sweep, back-to-back with the consumer always ready.
        out_ready = 1'b1;
        check_lat = 1;
        for (int i = 0; i < 8; i++) send(tbl[i]);
        drain();
        check_lat = 0;
        check("sweep_op_count", op_count, 8);
        check("sweep_sat_count", s_op_count, 3);

        // Backpressure: two accepted, third blocked until the consumer frees a slot.
        out_ready = 1'b0;
        base = n_out;
        send(tbl[8]);
        send(tbl[9]);
        present(tbl[10]);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready_low", in_ready, 0);
            check("bp_hold_y", {out_valid, y}, {1'b1, 8'h01});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_rise", in_ready, 1);
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        check("bp_transfers", n_out - base, 3);

        // Accumulator chain, no bubbles between acc_en transactions.
        for (int i = 11; i < 14; i++) send(tbl[i]);
        drain();

        // Reset with two entries in flight and a non-zero accumulator.
        out_ready = 1'b0;
        send(tbl[16]);
        send(tbl[17]);
        check("flight_full", in_ready, 0);
        pulse_rst();
        out_ready = 1'b1;
        send(tbl[18]);
        drain();

        // Flags and counter saturation at CNT_W=2.
        for (int i = 14; i < 16; i++) send(tbl[i]);
        drain();
        check("sat_count_3", s_op_count, 3);
        send(tbl[19]);
        send(tbl[20]);
        drain();
        check("op_count_5", op_count, 5);
        check("sat_count_5", s_op_count, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
